// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - start/busy/done handshake bundle between the pipeline and muldiv_seq
//
// Ports (signals):
//   start, op, signed_mode, in1, in2, flush : pipeline -> unit
//   busy, done, out_lo, out_hi, div_by_zero : unit -> pipeline
// Modports: master = pipeline side, slave = muldiv_seq side.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             signed_mode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             div_by_zero;

  modport master (
    output start, op, signed_mode, in1, in2, flush,
    input  busy, done, out_lo, out_hi, div_by_zero
  );

  modport slave (
    input  start, op, signed_mode, in1, in2, flush,
    output busy, done, out_lo, out_hi, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multicycle MUL/DIV/MOD unit with start/busy/done handshake
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : muldiv_seq_if.slave
//          in:  start, op (0=mul,1=div), signed_mode, in1, in2, flush
//          out: busy, done, out_lo (product lo / quotient),
//               out_hi (product hi / remainder), div_by_zero
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic             r_neg_q;    // product sign or quotient sign
  logic             r_neg_r;    // remainder sign (dividend sign)
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;       // accumulator high / partial remainder
  logic [WIDTH-1:0] r_lo;       // multiplier / dividend, shifted out as quotient shifts in
  logic [WIDTH-1:0] r_opb;      // multiplicand or divisor magnitude
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out_lo;
  logic [WIDTH-1:0] r_out_hi;
  logic             r_out_dbz;

  logic             w_accept;
  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic             w_dbz;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rsh;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Flush blocks a simultaneous start in IDLE and DONE.
  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start && !bus.flush;

  assign w_s1   = bus.signed_mode & bus.in1[WIDTH-1];
  assign w_s2   = bus.signed_mode & bus.in2[WIDTH-1];
  assign w_abs1 = w_s1 ? (~bus.in1 + 1'b1) : bus.in1;
  assign w_abs2 = w_s2 ? (~bus.in2 + 1'b1) : bus.in2;
  assign w_dbz  = bus.op && (bus.in2 == '0);

  // Shift-add: add multiplicand when the current multiplier bit is set,
  // then shift the whole {carry, hi, lo} right by one.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);

  // Restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor only if it fits. The remainder is always below the
  // divisor, so the difference fits in WIDTH bits when w_ge holds.
  assign w_rsh = {r_hi, r_lo[WIDTH-1]};
  assign w_ge  = (w_rsh >= {1'b0, r_opb});
  assign w_sub = w_rsh[WIDTH-1:0] - r_opb;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_q_fix    = r_neg_q ? (~r_lo + 1'b1) : r_lo;
  assign w_r_fix    = r_neg_r ? (~r_hi + 1'b1) : r_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opb     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_out_lo  <= '0;
      r_out_hi  <= '0;
      r_out_dbz <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op   <= bus.op;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_dbz) begin
              // No iterations: FIX passes these through unchanged.
              r_state <= S_FIX;
              r_lo    <= '1;
              r_hi    <= bus.in1;
              r_opb   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_hi    <= '0;
              r_neg_q <= w_s1 ^ w_s2;
              r_neg_r <= w_s1;
              r_dbz   <= 1'b0;
              if (bus.op) begin
                r_lo  <= w_abs1;
                r_opb <= w_abs2;
              end else begin
                r_lo  <= w_abs2;
                r_opb <= w_abs1;
              end
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_CALC: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_op) begin
              r_hi <= w_ge ? w_sub : w_rsh[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
              r_hi <= w_sum[WIDTH:1];
              r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= S_FIX;
            end
          end
        end

        S_FIX: begin
          r_busy <= 1'b0;
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_out_dbz <= r_dbz;
            if (r_op) begin
              r_out_lo <= w_q_fix;
              r_out_hi <= w_r_fix;
            end else begin
              r_out_lo <= w_prod_fix[WIDTH-1:0];
              r_out_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.out_lo      = r_out_lo;
  assign bus.out_hi      = r_out_hi;
  assign bus.div_by_zero = r_out_dbz;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multicycle multiply/divide unit with a start/busy/done handshake. It sequences the 32-bit MUL, DIV and MOD operations that the single-cycle ALU must not perform combinationally. It sits beside the ALU in the execute stage. The pipeline controller stalls on busy and captures hi/lo on done.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; accepted only in IDLE or DONE.
op  input  1  0 = multiply, 1 = divide.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
in1  input  WIDTH  multiplicand or dividend.
in2  input  WIDTH  multiplier or divisor.
flush  input  1  synchronous abort from the pipeline.
busy  output  1  high in CALC and FIX.
done  output  1  one-cycle pulse; results are valid.
out_lo  output  WIDTH  product low word, or quotient.
out_hi  output  WIDTH  product high word, or remainder.
div_by_zero  output  1  set with done when op=1 and in2=0.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, div_by_zero=0; out_lo=0, out_hi=0; iteration counter=0.
- States:
  - IDLE --start--> CALC, or FIX for divide-by-zero.
  - CALC: exactly WIDTH cycles, then FIX.
  - FIX: 1 cycle, then DONE.
  - DONE: 1 cycle, done=1. Goes to CALC or FIX if start=1, else IDLE.
- Acceptance: at the accepting edge, latch op and signed_mode.
  - Latch |in1| and |in2| when signed_mode=1; latch raw values otherwise.
  - Record sign flags: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
- start while busy=1 is ignored. It is not queued.
- Latency: start accepted at edge E0 → CALC during edges E0..E0+32 → FIX → done high after edge E0+33. Throughput is one operation per 34 cycles, back-to-back via DONE.
- Multiply:
  - Radix-2 shift-add over a 2*WIDTH accumulator, one multiplier bit per CALC cycle.
  - FIX negates the 2*WIDTH result if the sign flag is set.
  - {out_hi,out_lo} = full product.
- Divide:
  - Restoring division, one quotient bit per CALC cycle.
  - FIX applies the quotient and remainder signs independently.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - out_lo = quotient, out_hi = remainder.
- Divide-by-zero (op=1, in2=0 at acceptance): CALC is skipped (E0 → FIX → DONE, done after edge E0+1).
  - out_lo = all ones, out_hi = in1 (original, unmodified), div_by_zero=1.
- Signed overflow (-2^31 / -1): out_lo=0x80000000, out_hi=0. No flag.
- Outputs out_lo, out_hi and div_by_zero:
  - Update only at the FIX→DONE edge.
  - Hold until the next operation's FIX→DONE edge.
  - div_by_zero is cleared at that edge for normal operations.
- flush=1 in CALC or FIX:
  - Next edge → IDLE, busy=0.
  - No done pulse; outputs keep their previous values.
- flush in IDLE or DONE has no effect, except that in DONE it suppresses a simultaneous start.
- flush and start in the same cycle: flush wins; the start is dropped.
- rst asserted mid-operation clears everything immediately, independent of clk.
- The counter is WIDTH-bound: it never wraps inside an operation and is cleared on acceptance.

Test Plan:
- Unsigned multiply: in1=0xFFFFFFFF, in2=0xFFFFFFFF → done after edge E0+33; out_hi=0xFFFFFFFE, out_lo=0x00000001; busy high for exactly 33 cycles.
- Signed divide: in1=-7, in2=2 → out_lo=0xFFFFFFFD (-3), out_hi=0xFFFFFFFF (-1). Signed multiply: -3*5 → out_hi=0xFFFFFFFF, out_lo=0xFFFFFFF1.
- Divide-by-zero: op=1, in1=0x1234, in2=0 → done after edge E0+1; out_lo=0xFFFFFFFF, out_hi=0x1234, div_by_zero=1. A following valid divide 10/3 → out_lo=3, out_hi=1, div_by_zero=0.
- Overflow and unsigned: signed 0x80000000 / 0xFFFFFFFF → out_lo=0x80000000, out_hi=0. Unsigned 0x80000000 / 0xFFFFFFFF → out_lo=0, out_hi=0x80000000.
- Handshake:
  - start pulsed again at E0+5 with different operands → ignored; the result matches the first operands.
  - start held high through DONE → second operation accepted; done pulses at E0+33 and E0+67.
- Abort:
  - flush at E0+10 → busy=0 next cycle, no done, out_* unchanged.
  - rst asserted at E0+20 between edges → all outputs 0 immediately.
